// File: rtl/harry_pkg.sv
// Shared types for the Harry sprite animation path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package harry_pkg;

    // Sprite ROM frame codes; values 10-15 are never produced.
    typedef enum logic [3:0] {
        HS_STAND  = 4'd0,
        HS_JUMP   = 4'd1,
        HS_RUN1   = 4'd2,
        HS_RUN2   = 4'd3,
        HS_RUN3   = 4'd4,
        HS_RUN4   = 4'd5,
        HS_RUN5   = 4'd6,
        HS_VINE   = 4'd7,
        HS_CLIMB1 = 4'd8,
        HS_CLIMB2 = 4'd9
    } harry_state_t;

    typedef enum logic [2:0] {
        M_STAND,
        M_RUN,
        M_JUMP,
        M_VINE,
        M_CLIMB
    } mode_t;

    localparam int RUN_PHASES = 5;

endpackage

// File: rtl/frame_div.sv
// Frame-tick divider: counts enabled ticks and pulses wrap on the tick where it rolls over.
// Latency: wrap is combinational from the current count, qualified by tick/en/clr.
// Backpressure: none; advances only on Clk edges with tick=1.
// Ports: Clk, Reset_n (async, active-low), tick (frame strobe), en (count enable),
//        clr (synchronous clear on tick, overrides en), wrap (rollover pulse).
module frame_div #(
    parameter int DIV = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic tick,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;
    logic         at_end;

    assign at_end = (cnt == W'(DIV - 1));
    assign wrap   = tick & en & ~clr & at_end;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (tick) begin
            if (clr) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= at_end ? '0 : cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/harry_anim_ctrl.sv
// Harry animation sequencer: turns keys and physics flags into the 4-bit sprite frame code.
// Latency: one Clk after a sampled frame_tick, all outputs registered.
// Backpressure: none; every register holds on Clk edges without frame_tick.
// Ports: Clk, Reset_n (async, active-low), frame_tick, key_left/right/jump, climb_move,
//        on_ground/vine/ladder in; harry_state (sprite code), facing_left, jump_active out.
module harry_anim_ctrl #(
    parameter int RUN_DIV     = 4,
    parameter int CLIMB_DIV   = 8,
    parameter int JUMP_FRAMES = 32
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    input  logic       climb_move,
    input  logic       on_ground,
    input  logic       on_vine,
    input  logic       on_ladder,
    output logic [3:0] harry_state,
    output logic       facing_left,
    output logic       jump_active
);

    import harry_pkg::*;

    mode_t        mode, mode_nxt;
    harry_state_t state_nxt;
    logic         jump_prev;
    logic [7:0]   jump_cnt, jump_cnt_nxt;
    logic [2:0]   run_phase, run_phase_nxt;
    logic         climb_frame, climb_frame_nxt;
    logic         facing_nxt;
    logic         jump_rise, dir, jump_hold, mode_legal, jump_entry;
    logic         run_clr, run_wrap, climb_clr, climb_wrap;

    assign jump_rise = key_jump & ~jump_prev;
    assign dir       = key_left ^ key_right;

    // Mode selection in priority order. A jump is held until its minimum
    // duration has elapsed and the feet are back on the floor.
    always_comb begin
        jump_hold  = 1'b0;
        mode_legal = 1'b1;
        mode_nxt   = M_STAND;
        case (mode)
            M_STAND, M_RUN, M_VINE, M_CLIMB: jump_hold = 1'b0;
            M_JUMP:  jump_hold = !((jump_cnt == 8'd0) && on_ground);
            default: mode_legal = 1'b0;
        endcase
        if (!mode_legal)                mode_nxt = M_STAND;
        else if (on_vine)               mode_nxt = M_VINE;
        else if (on_ladder)             mode_nxt = M_CLIMB;
        else if (jump_hold)             mode_nxt = M_JUMP;
        else if (jump_rise && on_ground) mode_nxt = M_JUMP;
        else if (dir)                   mode_nxt = M_RUN;
        else                            mode_nxt = M_STAND;
    end

    // A fresh jump can start on the very tick the previous one lands.
    assign jump_entry = (mode_nxt == M_JUMP) && !jump_hold;

    // Cadence counters restart on entry and stay cleared outside their mode.
    assign run_clr   = (mode_nxt != M_RUN)   || (mode != M_RUN);
    assign climb_clr = (mode_nxt != M_CLIMB) || (mode != M_CLIMB);

    frame_div #(.DIV(RUN_DIV)) u_run_div (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .tick    (frame_tick),
        .en      (1'b1),
        .clr     (run_clr),
        .wrap    (run_wrap)
    );

    frame_div #(.DIV(CLIMB_DIV)) u_climb_div (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .tick    (frame_tick),
        .en      (climb_move),
        .clr     (climb_clr),
        .wrap    (climb_wrap)
    );

    always_comb begin
        jump_cnt_nxt = jump_cnt;
        if (jump_entry)
            jump_cnt_nxt = 8'(JUMP_FRAMES - 1);
        else if ((mode_nxt == M_JUMP) && (jump_cnt != 8'd0))
            jump_cnt_nxt = jump_cnt - 8'd1;

        run_phase_nxt = run_phase;
        if (run_clr)
            run_phase_nxt = 3'd0;
        else if (run_wrap)
            run_phase_nxt = (run_phase == 3'(RUN_PHASES - 1)) ? 3'd0 : run_phase + 3'd1;

        climb_frame_nxt = climb_frame;
        if (climb_clr)
            climb_frame_nxt = 1'b0;
        else if (climb_wrap)
            climb_frame_nxt = ~climb_frame;

        // Mirroring freezes while hanging on a vine or ladder.
        facing_nxt = facing_left;
        if (dir && (mode_nxt != M_VINE) && (mode_nxt != M_CLIMB))
            facing_nxt = key_left;

        state_nxt = HS_STAND;
        case (mode_nxt)
            M_STAND: state_nxt = HS_STAND;
            M_JUMP:  state_nxt = HS_JUMP;
            M_RUN:   state_nxt = harry_state_t'(4'(HS_RUN1) + 4'(run_phase_nxt));
            M_VINE:  state_nxt = HS_VINE;
            M_CLIMB: state_nxt = climb_frame_nxt ? HS_CLIMB2 : HS_CLIMB1;
            default: state_nxt = HS_STAND;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mode        <= M_STAND;
            jump_prev   <= 1'b0;
            jump_cnt    <= 8'd0;
            run_phase   <= 3'd0;
            climb_frame <= 1'b0;
            harry_state <= 4'd0;
            facing_left <= 1'b0;
            jump_active <= 1'b0;
        end else if (frame_tick) begin
            mode        <= mode_nxt;
            jump_prev   <= key_jump;
            jump_cnt    <= jump_cnt_nxt;
            run_phase   <= run_phase_nxt;
            climb_frame <= climb_frame_nxt;
            harry_state <= state_nxt;
            facing_left <= facing_nxt;
            jump_active <= (mode_nxt == M_JUMP);
        end
    end

endmodule

// File: tb/tb_harry_anim_ctrl.sv
module tb_harry_anim_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic       key_jump = 1'b0;
    logic       climb_move = 1'b0;
    logic       on_ground = 1'b0;
    logic       on_vine = 1'b0;
    logic       on_ladder = 1'b0;
    logic [3:0] harry_state;
    logic       facing_left;
    logic       jump_active;

    typedef struct {
        logic [3:0] st;
        logic       fl;
        logic       ja;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    harry_anim_ctrl dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_tick  (frame_tick),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_jump    (key_jump),
        .climb_move  (climb_move),
        .on_ground   (on_ground),
        .on_vine     (on_vine),
        .on_ladder   (on_ladder),
        .harry_state (harry_state),
        .facing_left (facing_left),
        .jump_active (jump_active)
    );

    task automatic compare(input string nm, input logic [3:0] st, input logic fl, input logic ja);
        checks++;
        if (harry_state !== st || facing_left !== fl || jump_active !== ja) begin
            errors++;
            $display("FAIL %s: got state=%0d facing_left=%0b jump_active=%0b, expected state=%0d facing_left=%0b jump_active=%0b",
                     nm, harry_state, facing_left, jump_active, st, fl, ja);
        end
    endtask

    // Issue one frame tick with the current inputs and queue its expected result.
    task automatic tick(input logic [3:0] st, input logic fl, input logic ja, input string nm);
        exp_t e;
        @(negedge Clk);
        e.st = st;
        e.fl = fl;
        e.ja = ja;
        e.nm = nm;
        sb.push_back(e);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        repeat (8) @(negedge Clk);
    endtask

    // Monitor: every sampled tick produces one registered output one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            if (frame_tick === 1'b1) begin
                @(negedge Clk);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: state=%0d with no expectation queued", harry_state);
                end else begin
                    e = sb.pop_front();
                    compare(e.nm, e.st, e.fl, e.ja);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, before any clock edge.
        #3;
        compare("reset_state", 4'd0, 1'b0, 1'b0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        // Run cycle: phase advances every 4 ticks, wraps after run5.
        key_right = 1'b1;
        on_ground = 1'b1;
        for (int i = 1; i <= 21; i++)
            tick(4'(2 + ((i - 1) / 4) % 5), 1'b0, 1'b0, "run_cycle");

        // Minimum-length jump with the key held; no retrigger while held.
        key_right = 1'b0;
        tick(4'd0, 1'b0, 1'b0, "run_release");
        key_jump = 1'b1;
        for (int i = 1; i <= 32; i++)
            tick(4'd1, 1'b0, 1'b1, "jump_hold");
        for (int i = 1; i <= 3; i++)
            tick(4'd0, 1'b0, 1'b0, "jump_land_no_retrigger");
        key_jump = 1'b0;
        tick(4'd0, 1'b0, 1'b0, "jump_key_release");

        // Jump that keeps falling past its minimum time; facing updates mid-air.
        key_jump = 1'b1;
        tick(4'd1, 1'b0, 1'b1, "fall_entry");
        on_ground = 1'b0;
        for (int i = 2; i <= 39; i++) begin
            key_left = (i == 10);
            tick(4'd1, (i >= 10), 1'b1, "fall");
        end
        on_ground = 1'b1;
        tick(4'd0, 1'b1, 1'b0, "fall_land");
        key_jump  = 1'b0;
        key_left  = 1'b1;
        key_right = 1'b1;
        tick(4'd0, 1'b1, 1'b0, "both_keys_stand");
        key_left  = 1'b0;
        key_right = 1'b0;

        // Jump aborted by ladder; climb cadence, freeze, resume. Facing holds on ladder.
        key_jump = 1'b1;
        tick(4'd1, 1'b1, 1'b1, "jump2_entry");
        on_ladder  = 1'b1;
        climb_move = 1'b1;
        key_right  = 1'b1;
        for (int i = 1; i <= 16; i++)
            tick((i <= 8) ? 4'd8 : 4'd9, 1'b1, 1'b0, "climb");
        climb_move = 1'b0;
        key_jump   = 1'b0;
        for (int i = 1; i <= 20; i++)
            tick(4'd9, 1'b1, 1'b0, "climb_frozen");
        climb_move = 1'b1;
        tick(4'd8, 1'b1, 1'b0, "climb_resume");

        // Run to code 4, then vine wins over a jump rise on the same tick.
        on_ladder  = 1'b0;
        climb_move = 1'b0;
        for (int i = 1; i <= 9; i++)
            tick((i <= 4) ? 4'd2 : ((i <= 8) ? 4'd3 : 4'd4), 1'b0, 1'b0, "run_to_phase2");
        key_right = 1'b0;
        key_left  = 1'b1;
        on_vine   = 1'b1;
        key_jump  = 1'b1;
        tick(4'd7, 1'b0, 1'b0, "vine_over_jump");
        on_vine  = 1'b0;
        key_jump = 1'b0;
        tick(4'd2, 1'b1, 1'b0, "run_after_vine");
        key_jump = 1'b1;
        tick(4'd1, 1'b1, 1'b1, "jump_from_run");

        // Asynchronous reset in the middle of a clock period.
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        compare("async_reset", 4'd0, 1'b0, 1'b0);
        key_left = 1'b0;
        key_jump = 1'b0;
        @(negedge Clk);
        compare("reset_held", 4'd0, 1'b0, 1'b0);
        Reset_n = 1'b1;

        // No tick: outputs and internal counters must hold while inputs churn.
        key_left = 1'b1;
        tick(4'd2, 1'b1, 1'b0, "t6_run_entry");
        for (int c = 1; c <= 100; c++) begin
            @(negedge Clk);
            key_left   = 1'($urandom_range(0, 1));
            key_right  = 1'($urandom_range(0, 1));
            key_jump   = 1'($urandom_range(0, 1));
            climb_move = 1'($urandom_range(0, 1));
            on_ground  = 1'($urandom_range(0, 1));
            on_vine    = 1'($urandom_range(0, 1));
            on_ladder  = 1'($urandom_range(0, 1));
            if (c % 25 == 0)
                compare("no_tick_hold", 4'd2, 1'b1, 1'b0);
        end
        key_left   = 1'b1;
        key_right  = 1'b0;
        key_jump   = 1'b0;
        climb_move = 1'b0;
        on_ground  = 1'b1;
        on_vine    = 1'b0;
        on_ladder  = 1'b0;
        for (int i = 2; i <= 4; i++)
            tick(4'd2, 1'b1, 1'b0, "t6_run_div_held");
        tick(4'd3, 1'b1, 1'b0, "t6_run_phase_adv");

        repeat (5) @(negedge Clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
